// File: rtl/mute_ramp.sv
// rtl/mute_ramp.sv - soft-mute gain ramp between the I2S deserializer and the NOS DAC
//
// Scales each stereo sample by a gain that ramps between silence (0) and unity (256).
// The ramp avoids clicks when the MCU toggles mute.
//
// Ports:
//   clk       master clock (mclk domain)
//   resetn    asynchronous active-low reset
//   mute      level-sensitive mute request, asynchronous to clk
//   in_data   [63:32] left, [31:0] right, signed, left-justified
//   in_valid  one-cycle strobe qualifying in_data
//   out_data  scaled sample, same packing as in_data, held between strobes
//   out_valid one-cycle strobe, two cycles after the matching in_valid
//   muted     high while the ramp sits in MUTED (drives the DAC mute pin)
//   gain      current gain, 0..256, 256 = unity
module mute_ramp #(
    parameter int STEP      = 1,
    parameter bit SYNC_MUTE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mute,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic        muted,
    output logic [8:0]  gain
);

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        UNMUTED   = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [9:0] STEP_W = 10'(STEP);
    localparam logic [9:0] UNITY  = 10'd256;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  gain_nxt;
    logic [1:0]  sync_q;
    logic        m_s;
    logic [9:0]  up_sum;
    logic [8:0]  gain_up;
    logic [8:0]  gain_dn;

    logic signed [40:0] prod_l_q;
    logic signed [40:0] prod_r_q;
    logic               v1_q;
    logic signed [40:0] sh_l;
    logic signed [40:0] sh_r;
    logic               unused_sh_bits;

    // Synchronizer resets to 1 so the block comes out of reset asking for mute.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], mute};
        end
    end

    assign m_s = SYNC_MUTE ? sync_q[1] : mute;

    // Saturating step in both directions; a 10-bit sum keeps the 256 ceiling visible.
    assign up_sum  = {1'b0, gain} + STEP_W;
    assign gain_up = (up_sum > UNITY) ? 9'd256 : up_sum[8:0];
    assign gain_dn = ({1'b0, gain} > STEP_W) ? (gain - STEP_W[8:0]) : 9'd0;

    // Gain moves according to the state before the edge, only on accepted samples.
    always_comb begin
        gain_nxt = gain;
        if (in_valid) begin
            case (state)
                RAMP_UP:   gain_nxt = gain_up;
                RAMP_DOWN: gain_nxt = gain_dn;
                default:   gain_nxt = gain;
            endcase
        end
    end

    // A reversal keeps the current gain, so direction changes never jump.
    always_comb begin
        state_nxt = state;
        case (state)
            MUTED: begin
                if (!m_s) state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (m_s)                    state_nxt = RAMP_DOWN;
                else if (gain_nxt == 9'd256) state_nxt = UNMUTED;
            end
            UNMUTED: begin
                if (m_s) state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (!m_s)                  state_nxt = RAMP_UP;
                else if (gain_nxt == 9'd0) state_nxt = MUTED;
            end
            default: state_nxt = MUTED;
        endcase
    end

    // muted is registered from the next state so it changes on the same edge as state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= MUTED;
            gain  <= 9'd0;
            muted <= 1'b1;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
            muted <= (state_nxt == MUTED);
        end
    end

    // Stage 1: multiply with the gain present in the sample's own cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod_l_q <= '0;
            prod_r_q <= '0;
            v1_q     <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                prod_l_q <= 41'($signed(in_data[63:32])) * 41'($signed({1'b0, gain}));
                prod_r_q <= 41'($signed(in_data[31:0]))  * 41'($signed({1'b0, gain}));
            end
        end
    end

    // |sample * gain| <= 2^39, so the low 32 bits of the shifted product never overflow.
    assign sh_l = prod_l_q >>> 8;
    assign sh_r = prod_r_q >>> 8;
    assign unused_sh_bits = ^{sh_l[40:32], sh_r[40:32]};

    // Stage 2: shift and pack; out_data holds between strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data  <= 64'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1_q;
            if (v1_q) begin
                out_data <= {sh_l[31:0], sh_r[31:0]};
            end
        end
    end

endmodule

// File: tb/tb_mute_ramp.sv
// tb/tb_mute_ramp.sv - scoreboard bench for mute_ramp (STEP=1 and STEP=4 instances)
module tb_mute_ramp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mute;
    logic        mute4;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_valid4;

    logic [63:0] out_data, out_data4;
    logic        out_valid, out_valid4;
    logic        muted, muted4;
    logic [8:0]  gain, gain4;

    always #5 clk = ~clk;

    mute_ramp #(.STEP(1), .SYNC_MUTE(1)) dut (
        .clk(clk), .resetn(resetn), .mute(mute), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .muted(muted), .gain(gain)
    );

    mute_ramp #(.STEP(4), .SYNC_MUTE(1)) dut4 (
        .clk(clk), .resetn(resetn), .mute(mute4), .in_data(in_data), .in_valid(in_valid4),
        .out_data(out_data4), .out_valid(out_valid4), .muted(muted4), .gain(gain4)
    );

    typedef struct packed {
        logic [63:0] data;
        int          at;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mg[2];
    int md[2];
    int stp[2] = '{1, 4};
    logic [63:0] last1 = '0;
    logic [63:0] last4 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] scale_ch(input logic [31:0] x, input int g);
        longint xs;
        longint p;
        xs = $signed(x);
        p  = xs * longint'(g);
        p  = p >>> 8;
        return p[31:0];
    endfunction

    function automatic logic [63:0] scale(input logic [63:0] d, input int g);
        return {scale_ch(d[63:32], g), scale_ch(d[31:0], g)};
    endfunction

    function automatic int sat(input int g);
        return (g < 0) ? 0 : ((g > 256) ? 256 : g);
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (5) step_clk();
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 after gap cycles.
    task automatic send(input bit w, input logic [63:0] d, input bit use_e,
                        input logic [63:0] e, input int gap);
        exp_t x;
        if (w) chk("gain4", 64'(gain4), 64'(mg[1]));
        else   chk("gain1", 64'(gain), 64'(mg[0]));
        x.data = use_e ? e : scale(d, mg[w]);
        x.at   = cyc + 2;
        in_data = d;
        if (w) begin
            in_valid4 = 1'b1;
            q4.push_back(x);
        end else begin
            in_valid = 1'b1;
            q1.push_back(x);
        end
        mg[w] = sat(mg[w] + md[w] * stp[w]);
        step_clk();
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        repeat (gap - 1) step_clk();
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!resetn) begin
            chk("rst_valid1", 64'(out_valid), 64'd0);
            chk("rst_data1", out_data, 64'd0);
            chk("rst_valid4", 64'(out_valid4), 64'd0);
            chk("rst_data4", out_data4, 64'd0);
            last1 = '0;
            last4 = '0;
        end else begin
            if (out_valid) begin
                if (q1.size() == 0) begin
                    chk("spurious1", 64'(out_valid), 64'd0);
                end else begin
                    x = q1.pop_front();
                    chk("data1", out_data, x.data);
                    chk("lat1", 64'(cyc), 64'(x.at));
                end
                last1 = out_data;
            end else begin
                chk("hold1", out_data, last1);
            end
            if (out_valid4) begin
                if (q4.size() == 0) begin
                    chk("spurious4", 64'(out_valid4), 64'd0);
                end else begin
                    x = q4.pop_front();
                    chk("data4", out_data4, x.data);
                    chk("lat4", 64'(cyc), 64'(x.at));
                end
                last4 = out_data4;
            end else begin
                chk("hold4", out_data4, last4);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; mute = 1'b1; mute4 = 1'b1;
        in_valid = 1'b0; in_valid4 = 1'b0; in_data = '0;
        mg = '{0, 0}; md = '{0, 0};

        repeat (3) step_clk();
        chk("rst_gain1", 64'(gain), 64'd0);
        chk("rst_muted1", 64'(muted), 64'd1);
        chk("rst_gain4", 64'(gain4), 64'd0);
        chk("rst_muted4", 64'(muted4), 64'd1);
        resetn = 1'b1;
        settle();
        chk("idle_muted1", 64'(muted), 64'd1);

        // Ramp up from silence, one sample every 4th cycle.
        mute = 1'b0;
        settle();
        chk("rampup_muted1", 64'(muted), 64'd0);
        md[0] = 1;
        for (int k = 0; k < 259; k++) send(1'b0, 64'h4000_0000_4000_0000, 1'b0, '0, 4);
        send(1'b0, 64'h4000_0000_4000_0000, 1'b1, 64'h4000_0000_4000_0000, 4);
        chk("unity_gain1", 64'(gain), 64'd256);
        chk("unity_muted1", 64'(muted), 64'd0);

        // Unity is bit-exact at the extremes.
        send(1'b0, 64'h8000_0000_7FFF_FFFF, 1'b1, 64'h8000_0000_7FFF_FFFF, 1);

        // Ramp down back-to-back; truncation toward -inf at gain 128; reverse at 100.
        mute = 1'b1;
        settle();
        md[0] = -1;
        while (mg[0] > 100) begin
            if (mg[0] == 128)
                send(1'b0, 64'hFFFF_FFFF_0000_0003, 1'b1, 64'hFFFF_FFFF_0000_0001, 1);
            else
                send(1'b0, {$urandom, $urandom}, 1'b0, '0, 1);
        end
        mute = 1'b0;
        settle();
        chk("reverse_gain1", 64'(gain), 64'd100);
        md[0] = 1;
        send(1'b0, {$urandom, $urandom}, 1'b0, '0, 1);
        send(1'b0, {$urandom, $urandom}, 1'b0, '0, 1);
        chk("reverse_muted1", 64'(muted), 64'd0);

        // STEP=4: up to unity, 100 samples of mute (clamps at 0 after 64), then up again.
        mute4 = 1'b0;
        settle();
        md[1] = 1;
        repeat (70) send(1'b1, {$urandom, $urandom}, 1'b0, '0, 1);
        chk("s4_unity", 64'(gain4), 64'd256);
        mute4 = 1'b1;
        settle();
        md[1] = -1;
        for (int k = 0; k < 100; k++) begin
            send(1'b1, {$urandom, $urandom}, 1'b0, '0, 1);
            if (k == 10) chk("s4_down_muted", 64'(muted4), 64'd0);
        end
        settle();
        chk("s4_floor_gain", 64'(gain4), 64'd0);
        chk("s4_floor_muted", 64'(muted4), 64'd1);
        mute4 = 1'b0;
        settle();
        md[1] = 1;
        chk("s4_rise_muted", 64'(muted4), 64'd0);
        repeat (10) send(1'b1, {$urandom, $urandom}, 1'b0, '0, 1);

        // Reset in the middle of a back-to-back burst drops in-flight samples.
        mute = 1'b1;
        mute4 = 1'b1;
        settle();
        md[0] = -1;
        md[1] = -1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                resetn = 1'b0;
                q1.delete();
                q4.delete();
                mg = '{0, 0};
                md = '{0, 0};
                in_data = {$urandom, $urandom};
                in_valid = 1'b1;
                step_clk();
                in_valid = 1'b0;
            end else begin
                if (i == 6) resetn = 1'b1;
                send(1'b0, {$urandom, $urandom}, 1'b0, '0, 1);
            end
        end
        settle();
        chk("post_rst_gain1", 64'(gain), 64'd0);
        chk("post_rst_muted1", 64'(muted), 64'd1);
        chk("post_rst_gain4", 64'(gain4), 64'd0);
        chk("post_rst_muted4", 64'(muted4), 64'd1);
        chk("drain1", 64'(q1.size()), 64'd0);
        chk("drain4", 64'(q4.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
